// File: rtl/referee_router.sv
`default_nettype none
// ============================================================================
// Module   : referee_router
// Purpose  : Moves words from one source FIFO into one of NUM_CH destination
//            FIFOs. The destination comes either from a header field in the
//            word (MODE 0) or from a round-robin pointer over the channels
//            that are not almost full (MODE 1). In MODE 0, words whose header
//            names a channel that does not exist are dropped and counted.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            empty, data_in       - source FIFO status / read data (valid the
//                                   cycle after pop)
//            almost_full[NUM_CH]  - per-destination back-pressure
//            pop                  - source FIFO read strobe
//            push[NUM_CH]         - per-destination write strobe (one-hot/0)
//            data_out             - shared destination write data
//            err_dest             - one-cycle pulse per dropped word
//            drop_cnt             - saturating dropped-word counter
//            busy                 - a word is in flight or held
// Revision : 1.0 - initial release
// ============================================================================
module referee_router #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 12,
   parameter int SEL_LSB = 10,
   parameter int MODE    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              empty,
   input  logic [DATA_W-1:0] data_in,
   input  logic [NUM_CH-1:0] almost_full,
   output logic              pop,
   output logic [NUM_CH-1:0] push,
   output logic [DATA_W-1:0] data_out,
   output logic              err_dest,
   output logic [7:0]        drop_cnt,
   output logic              busy
);

   localparam int SEL_W = $clog2(NUM_CH);

   logic              inflight_q,   inflight_d;
   logic              hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0] hold_data_q,  hold_data_d;
   logic [SEL_W-1:0]  hold_dest_q,  hold_dest_d;
   logic [SEL_W-1:0]  rr_ptr_q,     rr_ptr_d;
   logic              err_dest_q,   err_dest_d;
   logic [7:0]        drop_cnt_q,   drop_cnt_d;

   logic [SEL_W-1:0]  sel_field;
   logic              bad_dest;
   logic              any_free;
   logic [SEL_W-1:0]  grant;
   logic [SEL_W-1:0]  route_dest;
   logic              fire;
   int                rr_idx;

   assign sel_field = data_in[SEL_LSB +: SEL_W];
   // Only header routing can name a channel that does not exist.
   assign bad_dest  = (MODE == 0) && (int'(sel_field) >= NUM_CH);

   // Round-robin search: first free channel at or above rr_ptr, wrapping.
   always_comb begin
      any_free = 1'b0;
      grant    = '0;
      rr_idx   = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         rr_idx = (int'(rr_ptr_q) + i) % NUM_CH;
         if (!any_free && !almost_full[rr_idx]) begin
            any_free = 1'b1;
            grant    = SEL_W'(rr_idx);
         end
      end
   end

   always_comb begin
      if (MODE == 0) begin
         route_dest = hold_dest_q;
         fire       = !reset && hold_valid_q && !almost_full[hold_dest_q];
      end else begin
         route_dest = grant;
         fire       = !reset && hold_valid_q && any_free;
      end
   end

   // A new read is allowed only when nothing is outstanding and the hold
   // register is either empty or being emptied this cycle.
   assign pop = !reset && !empty && !inflight_q && (!hold_valid_q || fire);

   always_comb begin
      push = '0;
      if (fire) begin
         push[route_dest] = 1'b1;
      end
   end

   always_comb begin
      inflight_d   = pop;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_dest_d  = hold_dest_q;
      rr_ptr_d     = rr_ptr_q;
      err_dest_d   = 1'b0;
      drop_cnt_d   = drop_cnt_q;

      if (fire) begin
         hold_valid_d = 1'b0;
         if (MODE != 0) begin
            rr_ptr_d = SEL_W'((int'(grant) + 1) % NUM_CH);
         end
      end

      // Capture has priority over the clear so a same-edge refill sticks.
      if (inflight_q) begin
         if (bad_dest) begin
            err_dest_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end else begin
            hold_valid_d = 1'b1;
            hold_data_d  = data_in;
            hold_dest_d  = sel_field;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q   <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_dest_q  <= '0;
         rr_ptr_q     <= '0;
         err_dest_q   <= 1'b0;
         drop_cnt_q   <= 8'd0;
      end else begin
         inflight_q   <= inflight_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_dest_q  <= hold_dest_d;
         rr_ptr_q     <= rr_ptr_d;
         err_dest_q   <= err_dest_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign data_out = hold_data_q;
   assign err_dest = err_dest_q;
   assign drop_cnt = drop_cnt_q;
   assign busy     = inflight_q | hold_valid_q;

endmodule
`default_nettype wire
